serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// A single full-adder cell is reused once per clock. It processes operands
// LSB first and produces sum = a + b + c_in (mod 2^WIDTH), plus the carry-out.
// An operation takes WIDTH RUN cycles, then one DONE cycle, and then the
// block returns to IDLE.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Counter wide enough to hold WIDTH, so it never wraps inside an operation.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;       // operand A, shifted right each RUN cycle
    logic [WIDTH-1:0] b_sr;       // operand B, shifted right each RUN cycle
    logic [WIDTH-1:0] ps;         // partial sum, filled from the MSB end
    logic [WIDTH-1:0] ps_next;
    logic             carry;      // carry flop between successive bit slices
    logic [CW-1:0]    cnt;        // bits processed so far

    logic             p;
    logic             q;
    logic             sum_bit;
    logic             carry_bit;
    logic             last_bit;

    // The one full-adder cell, fed from the operand LSBs and the carry flop.
    assign p         = a_sr[0];
    assign q         = b_sr[0];
    assign sum_bit   = p ^ q ^ carry;
    assign carry_bit = (p & q) | (carry & (p ^ q));

    // This RUN edge processes bit WIDTH-1, so it completes the operation.
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 has
    // reached position 0.
    generate
        if (WIDTH == 1) begin : g_ps_one
            assign ps_next = sum_bit;
        end else begin : g_ps_many
            assign ps_next = {sum_bit, ps[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments, so every flop
        // samples the values from before the edge, regardless of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept start only in IDLE, leave RUN after the last bit.
    always_comb begin
        // NOTE: the default is assigned first, so no path through the case
        // leaves state_next unassigned. Without it, a latch would be inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift one bit slice per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    ps    <= ps_next;
                    carry <= carry_bit;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum   <= ps_next;
                        c_out <= carry_bit;
                    end
                end
                default: begin
                    // DONE: results are held, and the next edge returns to IDLE.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and randomized bench for serial_add_ctrl.
// An expected {c_out, sum} is queued whenever an accepted start is driven.
// The monitor pops it when done is seen and compares it with the result.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    int               checks   = 0;
    int               errors   = 0;
    int               done_cnt = 0;
    int               accepts  = 0;
    logic [WIDTH:0]   exp_q[$];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge. Outputs are sampled here and inputs
    // are driven here, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the full-width sum, including the carry-out.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < WIDTH + 4) begin
            step();
            n++;
        end
        check(tag, done, 1);
    endtask

    // One complete operation. The operands are scrambled after acceptance.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci);
        a     = x;
        b     = y;
        c_in  = ci;
        start = 1'b1;
        exp_q.push_back(model(x, y, ci));
        accepts++;
        step();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        c_in  = 1'($urandom_range(0, 1));
        wait_done("op_done_seen");
        step();
        check("op_idle_after", busy, 0);
    endtask

    // Scoreboard monitor: each done pulse pops and checks one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [WIDTH:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", done_cnt, accepts + 1000000);
            end else begin
                e = exp_q.pop_front();
                check("sb_sum", sum, e[WIDTH-1:0]);
                check("sb_c_out", c_out, e[WIDTH]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int last;
        int nlow;
        int d0;

        rst_n = 1'b0;
        start = 1'b1;          // reset must win over start
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        start = 1'b0;
        rst_n = 1'b1;
        step();

        // Basic timing: start at edge E, done only in the cycle after E+8.
        a     = 8'h5A;
        b     = 8'h3C;
        c_in  = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(8'h5A, 8'h3C, 1'b0));
        accepts++;
        step();                                  // edge E
        start = 1'b0;
        check("e1_busy", busy, 1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("e_done_early", done, 0);
            check("e_busy_run", busy, 1);
        end
        step();                                  // edge E+8
        check("e8_done", done, 1);
        check("e8_sum", sum, 8'h96);
        check("e8_c_out", c_out, 0);
        step();                                  // edge E+9
        check("e9_busy", busy, 0);
        check("e9_done", done, 0);

        // Carry-out boundary cases.
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);

        // start held high during RUN/DONE is ignored, and operands change freely.
        a     = 8'h01;
        b     = 8'h02;
        c_in  = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        accepts++;
        step();                                  // edge E
        a = 8'hAA;
        b = 8'h55;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("ign_busy", busy, 1);
        end
        check("ign_done", done, 1);
        check("ign_sum", sum, 8'h03);
        check("ign_c_out", c_out, 0);
        step();                                  // DONE -> IDLE
        check("ign_idle", busy, 0);
        exp_q.push_back(model(8'hAA, 8'h55, 1'b0));
        accepts++;
        step();                                  // second operation accepted
        check("ign_second_accept", busy, 1);
        start = 1'b0;
        wait_done("ign_second_done");
        step();

        // start held continuously: accept, 8 RUN, DONE, IDLE -> 10-edge period.
        a     = 8'h12;
        b     = 8'h34;
        c_in  = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back(model(8'h12, 8'h34, 1'b0));
        accepts += 3;
        start = 1'b1;
        nd    = 0;
        last  = 0;
        nlow  = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done === 1'b1) begin
                if (nd > 0) check("cont_spacing", i - last, WIDTH + 2);
                last = i;
                nd++;
            end
            if (busy === 1'b0) nlow++;
        end
        start = 1'b0;
        check("cont_done_count", nd, 3);
        check("cont_busy_low", nlow, 3);
        step();

        // Reset mid-operation discards the operation.
        run_op(8'h5A, 8'h3C, 1'b0);
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        step();                                  // edge E, accepted
        start = 1'b0;
        step();
        step();
        step();                                  // edges E+1..E+3
        rst_n = 1'b0;
        step();                                  // 4th RUN edge
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_c_out", c_out, 0);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (12) step();
        check("abort_no_done", done_cnt, d0);
        run_op(8'h10, 8'h20, 1'b0);
        check("abort_next_sum", sum, 8'h30);

        // Randomized operations with random gaps between them.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) step();
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        step();
        check("done_vs_accepts", done_cnt, accepts);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
